// File: rtl/cascade_stage_sequencer.sv
// Sequencer that walks one window through NUM_STAGES cascade stages on a shared classifier.
// Define STAGE_WATCHDOG_EN to add a per-stage watchdog that rejects a stage that never completes.
module cascade_stage_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int STAGE_ID_WIDTH  = 2,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                      clk_fpga,
    input  logic                      reset_fpga,
    input  logic                      i_window_valid,
    output logic                      o_window_ready,
    input  logic                      i_abort,
    output logic                      o_stage_start,
    output logic [STAGE_ID_WIDTH-1:0] o_stage_id,
    input  logic                      i_stage_done,
    input  logic                      i_stage_pass,
    output logic                      o_result_valid,
    output logic                      o_iscandidate,
    output logic [STAGE_ID_WIDTH-1:0] o_reject_stage,
    output logic                      o_timeout,
    output logic                      o_busy
);

    if (NUM_STAGES < 1 || NUM_STAGES > (1 << STAGE_ID_WIDTH) || WATCHDOG_CYCLES < 2) begin : g_bad_params
        $error("cascade_stage_sequencer: illegal NUM_STAGES/STAGE_ID_WIDTH/WATCHDOG_CYCLES");
    end

    localparam logic [STAGE_ID_WIDTH-1:0] LAST_STAGE = STAGE_ID_WIDTH'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t                    state;
    logic [STAGE_ID_WIDTH-1:0] stage_idx;
    logic                      wd_expire;

    assign o_stage_id = stage_idx;

`ifdef STAGE_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_WIDTH-1:0] wd_count;
    logic                timeout_q;

    // Expiry is the WATCHDOG_CYCLES-th waiting cycle; a done in that same cycle takes precedence.
    assign wd_expire = (state == WAIT) && !i_stage_done &&
                       (wd_count == WD_WIDTH'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga || state != WAIT) begin
            wd_count <= '0;
        end else if (!i_stage_done) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            timeout_q <= 1'b0;
        end else if (!i_abort && state == WAIT && (i_stage_done || wd_expire)) begin
            timeout_q <= !i_stage_done;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state          <= IDLE;
            stage_idx      <= '0;
            o_stage_start  <= 1'b0;
            o_result_valid <= 1'b0;
            o_iscandidate  <= 1'b0;
            o_reject_stage <= '0;
            o_busy         <= 1'b0;
            o_window_ready <= 1'b1;
        end else begin
            o_stage_start  <= 1'b0;
            o_result_valid <= 1'b0;
            // Abort flushes the window without touching the last verdict, even if done arrives too.
            if (i_abort) begin
                state          <= IDLE;
                o_busy         <= 1'b0;
                o_window_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_window_valid) begin
                            stage_idx      <= '0;
                            state          <= START;
                            o_stage_start  <= 1'b1;
                            o_busy         <= 1'b1;
                            o_window_ready <= 1'b0;
                        end
                    end
                    START: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (i_stage_done) begin
                            if (i_stage_pass && stage_idx == LAST_STAGE) begin
                                o_iscandidate  <= 1'b1;
                                o_reject_stage <= '0;
                                o_result_valid <= 1'b1;
                                state          <= DONE;
                            end else if (i_stage_pass) begin
                                stage_idx     <= stage_idx + 1'b1;
                                o_stage_start <= 1'b1;
                                state         <= START;
                            end else begin
                                o_iscandidate  <= 1'b0;
                                o_reject_stage <= stage_idx;
                                o_result_valid <= 1'b1;
                                state          <= DONE;
                            end
                        end else if (wd_expire) begin
                            o_iscandidate  <= 1'b0;
                            o_reject_stage <= stage_idx;
                            o_result_valid <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    DONE: begin
                        state          <= IDLE;
                        o_busy         <= 1'b0;
                        o_window_ready <= 1'b1;
                    end
                    default: begin
                        state          <= IDLE;
                        o_busy         <= 1'b0;
                        o_window_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cascade_stage_sequencer.sv
// Bench for cascade_stage_sequencer: vector table plus abort/reset/back-to-back/watchdog sequences,
// with verdicts checked through a scoreboard queue on every o_result_valid.
module tb_cascade_stage_sequencer;

    logic       clk_fpga = 1'b0;
    logic       reset_fpga;
    logic       i_window_valid;
    logic       o_window_ready;
    logic       i_abort;
    logic       o_stage_start;
    logic [1:0] o_stage_id;
    logic       i_stage_done;
    logic       i_stage_pass;
    logic       o_result_valid;
    logic       o_iscandidate;
    logic [1:0] o_reject_stage;
    logic       o_timeout;
    logic       o_busy;

    cascade_stage_sequencer #(
        .NUM_STAGES     (3),
        .STAGE_ID_WIDTH (2),
        .WATCHDOG_CYCLES(8)
    ) dut (
        .clk_fpga      (clk_fpga),
        .reset_fpga    (reset_fpga),
        .i_window_valid(i_window_valid),
        .o_window_ready(o_window_ready),
        .i_abort       (i_abort),
        .o_stage_start (o_stage_start),
        .o_stage_id    (o_stage_id),
        .i_stage_done  (i_stage_done),
        .i_stage_pass  (i_stage_pass),
        .o_result_valid(o_result_valid),
        .o_iscandidate (o_iscandidate),
        .o_reject_stage(o_reject_stage),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        logic [2:0] pass_mask;
        int         latency;
        logic       exp_cand;
        logic [1:0] exp_reject;
        logic       exp_timeout;
        int         exp_starts;
        int         exp_cycles;
        int         kill_stage;
        int         kill_kind;
    } vec_t;

    typedef struct {
        logic       cand;
        logic [1:0] reject;
        logic       timeout;
        int         due;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cycle    = 0;

    always @(posedge clk_fpga) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Every verdict must match the oldest expected record, arriving on its predicted cycle.
    always @(negedge clk_fpga) begin
        if (o_result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result actual=1 expected=0 at cycle %0d", cycle);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                checkOutput("sb_cand", o_iscandidate, e.cand);
                checkOutput("sb_reject", o_reject_stage, e.reject);
                checkOutput("sb_timeout", o_timeout, e.timeout);
                checkOutput("sb_latency", cycle, e.due);
            end
        end
    end

    task automatic clearInputs();
        i_window_valid = 1'b0;
        i_stage_done   = 1'b0;
        i_stage_pass   = 1'b0;
        i_abort        = 1'b0;
        reset_fpga     = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        int w;
        w = 0;
        while (!o_window_ready && w < 20) begin
            @(negedge clk_fpga);
            w++;
        end
        checkOutput({tag, "_ready"}, o_window_ready, 1);
    endtask

    // Runs one window with a responder that answers each start after v.latency cycles.
    task automatic applyStimulus(input vec_t v, input string tag);
        int  starts;
        int  done_cyc;
        int  cur_id;
        bit  finished;
        bit  killed;
        sb_t e;
        waitReady(tag);
        i_window_valid = 1'b1;
        if (v.kill_kind == 0) begin
            e.cand    = v.exp_cand;
            e.reject  = v.exp_reject;
            e.timeout = v.exp_timeout;
            e.due     = cycle + v.exp_cycles;
            sb_q.push_back(e);
        end
        starts   = 0;
        done_cyc = -1;
        cur_id   = 0;
        finished = 0;
        killed   = 0;
        for (int c = 1; c <= 60 && !finished; c++) begin
            @(negedge clk_fpga);
            clearInputs();
            if (o_stage_start) begin
                checkOutput({tag, "_start_id"}, o_stage_id, starts);
                cur_id   = starts;
                starts++;
                done_cyc = c + v.latency;
            end
            if (o_result_valid) begin
                finished = 1;
                checkOutput({tag, "_starts"}, starts, v.exp_starts);
            end else if (c == done_cyc) begin
                checkOutput({tag, "_id_stable"}, o_stage_id, cur_id);
                if (v.kill_kind != 0 && cur_id == v.kill_stage) begin
                    i_abort      = (v.kill_kind == 1);
                    reset_fpga   = (v.kill_kind == 2);
                    i_stage_done = 1'b1;
                    i_stage_pass = 1'b1;
                    finished     = 1;
                    killed       = 1;
                end else begin
                    i_stage_done = 1'b1;
                    i_stage_pass = (cur_id < 3) ? v.pass_mask[cur_id] : 1'b0;
                end
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_no_result actual=0 expected=1", tag);
        end
        @(negedge clk_fpga);
        clearInputs();
        checkOutput({tag, "_post_ready"}, o_window_ready, 1);
        checkOutput({tag, "_post_busy"}, o_busy, 0);
        if (killed) begin
            checkOutput({tag, "_kill_starts"}, starts, v.exp_starts);
            checkOutput({tag, "_kill_result"}, o_result_valid, 0);
            checkOutput({tag, "_kill_start"}, o_stage_start, 0);
            checkOutput({tag, "_kill_cand"}, o_iscandidate, v.exp_cand);
            checkOutput({tag, "_kill_reject"}, o_reject_stage, v.exp_reject);
            checkOutput({tag, "_kill_timeout"}, o_timeout, v.exp_timeout);
            if (v.kill_kind == 2) checkOutput({tag, "_kill_id"}, o_stage_id, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout actual=%0d expected<100000", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        // mask bit i = verdict of stage i; cycles = accept to result_valid
        vecs[0] = '{3'b111, 1, 1'b1, 2'd0, 1'b0, 3, 7,  -1, 0};
        vecs[1] = '{3'b101, 1, 1'b0, 2'd1, 1'b0, 2, 5,  -1, 0};
        vecs[2] = '{3'b110, 1, 1'b0, 2'd0, 1'b0, 1, 3,  -1, 0};
        vecs[3] = '{3'b011, 2, 1'b0, 2'd2, 1'b0, 3, 10, -1, 0};
        vecs[4] = '{3'b111, 3, 1'b1, 2'd0, 1'b0, 3, 13, -1, 0};
        vecs[5] = '{3'b001, 4, 1'b0, 2'd1, 1'b0, 2, 11, -1, 0};

        clearInputs();
        reset_fpga     = 1'b1;
        i_window_valid = 1'b1;
        i_stage_done   = 1'b1;
        repeat (3) @(negedge clk_fpga);
        checkOutput("rst_start", o_stage_start, 0);
        checkOutput("rst_result", o_result_valid, 0);
        checkOutput("rst_cand", o_iscandidate, 0);
        checkOutput("rst_reject", o_reject_stage, 0);
        checkOutput("rst_timeout", o_timeout, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_ready", o_window_ready, 1);
        checkOutput("rst_id", o_stage_id, 0);
        clearInputs();
        @(negedge clk_fpga);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort colliding with a passing done in stage 2: verdict from vec5 must survive.
        v = '{3'b111, 1, 1'b0, 2'd1, 1'b0, 3, 0, 2, 1};
        applyStimulus(v, "abort_coll");
        repeat (3) @(negedge clk_fpga);

        // All-pass sets candidate, then reset mid-WAIT of stage 1 must clear it and produce nothing.
        applyStimulus(vecs[0], "pre_reset");
        v = '{3'b111, 2, 1'b0, 2'd0, 1'b0, 2, 0, 1, 2};
        applyStimulus(v, "reset_wait");
        applyStimulus(vecs[1], "post_reset");

        // Window held valid across the result cycle is taken one cycle later from IDLE.
        waitReady("chain");
        i_window_valid = 1'b1;
        sb_q.push_back('{1'b0, 2'd0, 1'b0, cycle + 3});
        @(negedge clk_fpga);
        checkOutput("chain_start0", o_stage_start, 1);
        @(negedge clk_fpga);
        i_stage_done = 1'b1;
        i_stage_pass = 1'b0;
        @(negedge clk_fpga);
        i_stage_done = 1'b0;
        checkOutput("chain_result", o_result_valid, 1);
        checkOutput("chain_ready_done", o_window_ready, 0);
        @(negedge clk_fpga);
        checkOutput("chain_ready_idle", o_window_ready, 1);
        checkOutput("chain_no_start", o_stage_start, 0);
        @(negedge clk_fpga);
        checkOutput("chain_start1", o_stage_start, 1);
        checkOutput("chain_id1", o_stage_id, 0);
        i_window_valid = 1'b0;
        i_abort        = 1'b1;
        @(negedge clk_fpga);
        i_abort = 1'b0;
        checkOutput("chain_abort_busy", o_busy, 0);
        checkOutput("chain_abort_cand", o_iscandidate, 0);

        // Stray done/pass while idle is ignored.
        i_stage_done = 1'b1;
        i_stage_pass = 1'b1;
        repeat (3) @(negedge clk_fpga);
        checkOutput("idle_done_busy", o_busy, 0);
        checkOutput("idle_done_start", o_stage_start, 0);
        clearInputs();
        @(negedge clk_fpga);

`ifdef STAGE_WATCHDOG_EN
        // Stage 0 hangs: expiry on the 8th waiting cycle, result at T+10.
        v = '{3'b111, 100, 1'b0, 2'd0, 1'b1, 1, 10, -1, 0};
        applyStimulus(v, "wd_hang");
        // Done on the expiry cycle of every stage wins: all pass, 3*(8+1)+1 cycles.
        v = '{3'b111, 8, 1'b1, 2'd0, 1'b0, 3, 28, -1, 0};
        applyStimulus(v, "wd_edge");
`endif

        repeat (3) @(negedge clk_fpga);
        checkOutput("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
